// File: rtl/draw_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | draw_pkg : engine ids, mux state encoding and default field widths |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package draw_pkg;

  localparam int DEF_NUM_SRC = 16;
  localparam int DEF_SEL_W   = 4;
  localparam int DEF_X_W     = 9;
  localparam int DEF_Y_W     = 9;
  localparam int DEF_COL_W   = 8;

  localparam logic [3:0] ENG_CF   = 4'd0;
  localparam logic [3:0] ENG_CD   = 4'd1;
  localparam logic [3:0] ENG_RF   = 4'd2;
  localparam logic [3:0] ENG_RD   = 4'd3;
  localparam logic [3:0] ENG_LD   = 4'd4;
  localparam logic [3:0] ENG_FU   = 4'd10;
  localparam logic [3:0] ENG_IDLE = 4'd15;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } mux_state_e;

endpackage
`default_nettype wire

// File: rtl/draw_src_mux_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | draw_src_mux_if : engine-side and writer-side bundle of the mux    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface draw_src_mux_if
  import draw_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int COL_W   = DEF_COL_W
);

  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*X_W-1:0]   src_x;
  logic [NUM_SRC*Y_W-1:0]   src_y;
  logic [NUM_SRC*COL_W-1:0] src_col;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_last;
  logic [NUM_SRC-1:0]       src_ready;
  logic [X_W-1:0]           out_x;
  logic [Y_W-1:0]           out_y;
  logic [COL_W-1:0]         out_col;
  logic                     out_last;
  logic [SEL_W-1:0]         out_src;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  // The mux itself.
  modport slave (
    input  sel, src_x, src_y, src_col, src_valid, src_last, out_ready,
    output src_ready, out_x, out_y, out_col, out_last, out_src, out_valid, busy
  );

  // Engines plus frame-buffer writer.
  modport master (
    output sel, src_x, src_y, src_col, src_valid, src_last, out_ready,
    input  src_ready, out_x, out_y, out_col, out_last, out_src, out_valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/draw_skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | draw_skid_buf : 2-entry valid/ready buffer (output reg + skid reg) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module draw_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         full
);

  logic [W-1:0] skid_data;
  logic         skid_valid;
  logic         in_acc;
  logic         out_acc;

  // Ready comes only from the skid flag so it never depends on out_ready.
  assign in_ready = !skid_valid;
  assign full     = skid_valid;
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_acc) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_acc;
        if (in_acc) begin
          out_data <= in_data;
        end
      end
    end else if (in_acc) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/draw_src_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | draw_src_mux : per-primitive locked selector of draw-engine beats   |
// | Optional clipping: define DRAW_SRC_MUX_CLIP_EN.   Rev 1.0           |
// +--------------------------------------------------------------------+
module draw_src_mux
  import draw_pkg::*;
#(
  parameter int NUM_SRC  = DEF_NUM_SRC,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COL_W    = DEF_COL_W,
  parameter int IDLE_ID  = int'(ENG_IDLE),
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic           clk,
  input  logic           rst,
  draw_src_mux_if.slave  bus
);

  localparam int PW = 1 + COL_W + Y_W + X_W;

  mux_state_e       state;
  mux_state_e       state_next;
  logic [SEL_W-1:0] lock;
  logic [SEL_W-1:0] lock_next;

  logic [X_W-1:0]   cur_x;
  logic [Y_W-1:0]   cur_y;
  logic [COL_W-1:0] cur_col;
  logic             cur_valid;
  logic             cur_last;

  logic             sel_ok;
  logic             accept;
  logic             clipped;
  logic             skid_full;
  logic             pipe_in_ready;
  logic             pipe_valid;
  logic [PW-1:0]    pipe_out;

  always_comb begin
    cur_x     = '0;
    cur_y     = '0;
    cur_col   = '0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (lock == SEL_W'(i)) begin
        cur_x     = bus.src_x[i*X_W +: X_W];
        cur_y     = bus.src_y[i*Y_W +: Y_W];
        cur_col   = bus.src_col[i*COL_W +: COL_W];
        cur_valid = bus.src_valid[i];
        cur_last  = bus.src_last[i];
      end
    end
  end

  assign sel_ok = (int'(bus.sel) < NUM_SRC) && (int'(bus.sel) != IDLE_ID);
  assign accept = (state == ST_LOCKED) && cur_valid && !skid_full;

`ifdef DRAW_SRC_MUX_CLIP_EN
  // Off-screen beats are still consumed from the engine, just never forwarded.
  assign clipped = (int'(cur_x) >= SCREEN_W) || (int'(cur_y) >= SCREEN_H);
`else
  logic unused_clip_bounds;
  assign unused_clip_bounds = ^{SCREEN_W[0], SCREEN_H[0]};
  assign clipped = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      lock  <= '0;
    end else begin
      state <= state_next;
      lock  <= lock_next;
    end
  end

  always_comb begin
    state_next = state;
    lock_next  = lock;
    case (state)
      ST_IDLE: begin
        if (sel_ok) begin
          state_next = ST_LOCKED;
          lock_next  = bus.sel;
        end
      end
      ST_LOCKED: begin
        if (accept && cur_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_ready[i] = (state == ST_LOCKED) && (lock == SEL_W'(i)) && !skid_full;
    end
  end

  draw_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({cur_last, cur_col, cur_y, cur_x}),
    .in_valid  (accept && !clipped),
    .in_ready  (pipe_in_ready),
    .out_data  (pipe_out),
    .out_valid (pipe_valid),
    .out_ready (bus.out_ready),
    .full      (skid_full)
  );

  logic unused_in_ready;
  assign unused_in_ready = pipe_in_ready;

  assign {bus.out_last, bus.out_col, bus.out_y, bus.out_x} = pipe_out;
  assign bus.out_valid = pipe_valid;
  assign bus.out_src   = lock;
  assign bus.busy      = (state == ST_LOCKED) || pipe_valid || skid_full;

endmodule
`default_nettype wire

// File: doc/draw_src_mux.md
Name: draw_src_mux

Overview:
- N-channel pixel-stream selector between the draw engines and the frame-buffer writer.
- Draw engines: circle fill/draw, rect fill/draw, line draw, frame update.
- Routes X, Y and colour from the engine chosen by SEL through a valid/ready handshake with a registered, backpressure-safe output.
- Generalises the earlier X-only registered mux:
  - parametrised source count and field widths;
  - full handshake;
  - lock-per-primitive arbitration, released on a LAST beat.

Parameters:
NUM_SRC, 16, number of source slots (SEL values 0..NUM_SRC-1)
SEL_W, 4, width of SEL/OUT_SRC
X_W, 9, X coordinate width
Y_W, 9, Y coordinate width
COL_W, 8, colour width
IDLE_ID, 15, SEL value meaning "no engine"; never locked
SCREEN_W, 320, clip bound on X (optional feature only)
SCREEN_H, 240, clip bound on Y (optional feature only)

Ports:
CLK  input  1  single clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
SEL  input  SEL_W  engine id from command decoder
SRC_X  input  NUM_SRC*X_W  flattened, slot i at [i*X_W +: X_W]
SRC_Y  input  NUM_SRC*Y_W  flattened per slot
SRC_COL  input  NUM_SRC*COL_W  flattened per slot
SRC_VALID  input  NUM_SRC  per-source beat valid
SRC_LAST  input  NUM_SRC  per-source last beat of primitive
SRC_READY  output  NUM_SRC  per-source accept
OUT_X  output  X_W  selected X
OUT_Y  output  Y_W  selected Y
OUT_COL  output  COL_W  selected colour
OUT_LAST  output  1  last beat of primitive
OUT_SRC  output  SEL_W  id of locked source
OUT_VALID  output  1  output beat valid
OUT_READY  input  1  downstream accept
BUSY  output  1  high while LOCKED or beats pending

Behaviour:
- Reset (synchronous, RST high at a clock edge) forces:
  - state IDLE;
  - both buffer entries empty;
  - OUT_X, OUT_Y, OUT_COL, OUT_LAST, OUT_SRC, OUT_VALID, SRC_READY and BUSY all 0.
- Reset mid-primitive drops all buffered beats; nothing is replayed.
- State machine:
  - IDLE -> LOCKED when SEL < NUM_SRC and SEL != IDLE_ID. The lock register takes SEL, OUT_SRC updates the same edge, and SRC_READY is 0 during IDLE.
  - LOCKED: SEL is ignored. SRC_READY[lock] = !skid_full; all other SRC_READY bits are 0.
  - LOCKED -> IDLE on the edge after a beat with SRC_LAST=1 is accepted from the locked source. The next lock can occur in the cycle following, so there are no gap cycles beyond the one IDLE sample.
- Datapath: 2-entry pipeline, an output register plus a skid register.
  - Source beat accepted when SRC_VALID[lock] & SRC_READY[lock]; output beat consumed when OUT_VALID & OUT_READY.
  - Latency: accepted beat appears on OUT_* the next cycle when the pipeline is empty.
  - Throughput: 1 beat/cycle while OUT_READY=1.
  - OUT_* stable while OUT_VALID & !OUT_READY.
  - Simultaneous accept and consume with the skid empty: the beat goes directly to the output register.
  - Skid full: SRC_READY deasserts combinationally from registered state, not from OUT_READY.
  - Ordering preserved; no loss or duplication.
- BUSY = (state==LOCKED) | OUT_VALID | skid_full.
- SEL values >= NUM_SRC or == IDLE_ID: remain IDLE, no error flag.
- Field slicing is width-exact; there is no truncation or extension in the datapath.

Optional Feature:
- Macro DRAW_SRC_MUX_CLIP_EN.
- With the macro defined:
  - A beat with X >= SCREEN_W or Y >= SCREEN_H is accepted from the source (SRC_READY as normal) but not written into the pipeline.
  - If a clipped beat carries LAST, unlock still occurs; OUT_LAST is then not emitted for that primitive.
- Without the macro: every beat is forwarded, and SCREEN_W/SCREEN_H are unused.

Decomposition:
- Package draw_pkg holds:
  - engine id constants CF=0, CD=1, RF=2, RD=3, LD=4, FU=10, IDLE=15;
  - state enum {IDLE, LOCKED};
  - default width constants.
- One sub-module, draw_skid_buf: a 2-entry valid/ready skid buffer parametrised on payload width. The top level concatenates {LAST, COL, Y, X}.

Test Plan:
1. Reset: RST=1 for 2 cycles with all SRC_VALID=1 and SEL=3 -> OUT_VALID=0, SRC_READY=0, BUSY=0, all OUT_* = 0.
2. SEL=3, source 3 sends X=10..13 (LAST on 13), OUT_READY=1 -> OUT_X=10,11,12,13 on consecutive cycles, first one cycle after accept; OUT_LAST only with 13; OUT_SRC=3; BUSY falls the cycle after 13 is consumed.
3. Backpressure: OUT_READY=0 for 3 cycles mid-stream -> OUT_X held; SRC_READY[3] falls once 2 beats are held; after release the output sequence has no gaps, losses or duplicates.
4. Locked to 2, SEL changes to 4 -> ignored until source 2's LAST is accepted, then OUT_SRC=4. SEL=15 -> stays IDLE, SRC_READY all 0.
5. Reset asserted after 2 of 5 beats -> next cycle all outputs 0 and state IDLE; a new SEL=1 stream then starts cleanly.
6. With DRAW_SRC_MUX_CLIP_EN: beats X=5, X=400, X=6 (LAST) -> OUT_X=5, 6 only; all three accepted; OUT_LAST with 6.
